// File: rtl/month_year_counter_pkg.sv
// Shared calendar constants for the month/year stage and the day counter:
// BCD month codes, days-per-month values and the default reset date.
package month_year_counter_pkg;

  localparam logic [7:0] M_JAN = 8'h01;
  localparam logic [7:0] M_FEB = 8'h02;
  localparam logic [7:0] M_MAR = 8'h03;
  localparam logic [7:0] M_APR = 8'h04;
  localparam logic [7:0] M_MAY = 8'h05;
  localparam logic [7:0] M_JUN = 8'h06;
  localparam logic [7:0] M_JUL = 8'h07;
  localparam logic [7:0] M_AUG = 8'h08;
  localparam logic [7:0] M_SEP = 8'h09;
  localparam logic [7:0] M_OCT = 8'h10;
  localparam logic [7:0] M_NOV = 8'h11;
  localparam logic [7:0] M_DEC = 8'h12;

  localparam logic [4:0] DAYS_28 = 5'd28;
  localparam logic [4:0] DAYS_29 = 5'd29;
  localparam logic [4:0] DAYS_30 = 5'd30;
  localparam logic [4:0] DAYS_31 = 5'd31;

  localparam logic [3:0]  DEFAULT_MONTH = 4'd1;
  localparam logic [15:0] DEFAULT_YEAR  = 16'h2025;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/month_year_counter_leap_year_detect.sv
// Gregorian leap-year detector working directly on a 4-digit BCD year.
// Purely combinational so it can be shared with a day-of-week block.
module leap_year_detect (
  input  logic [3:0] yth,
  input  logic [3:0] yh,
  input  logic [3:0] yt,
  input  logic [3:0] yu,
  output logic       leap
);

  logic [6:0] y2;
  logic [6:0] c2;

  assign y2 = ({3'b000, yt} * 7'd10) + {3'b000, yu};
  assign c2 = ({3'b000, yth} * 7'd10) + {3'b000, yh};

  // Century years (y2 == 0) are leap only when the century is divisible by 4.
  assign leap = ((y2 % 7'd4) == 7'd0) &&
                ((y2 != 7'd0) || ((c2 % 7'd4) == 7'd0));

endmodule

// File: rtl/month_year_counter.sv
// Month (BCD 01-12) and 4-digit BCD year counter advanced by the day counter's
// rollover pulse, with validated parallel load, leap flag and days-in-month.
module month_year_counter
  import month_year_counter_pkg::*;
#(
  parameter logic [3:0]  RST_MONTH = DEFAULT_MONTH,
  parameter logic [15:0] RST_YEAR  = DEFAULT_YEAR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        load_en,
  input  logic [3:0]  load_month,
  input  logic [15:0] load_year,
  output logic [3:0]  mu,
  output logic [3:0]  mt,
  output logic [3:0]  yu,
  output logic [3:0]  yt,
  output logic [3:0]  yh,
  output logic [3:0]  yth,
  output logic        leap,
  output logic [4:0]  max_days,
  output logic        cout,
  output logic        load_err
);

  localparam logic [3:0] RST_MT = (RST_MONTH >= 4'd10) ? 4'd1 : 4'd0;
  localparam logic [3:0] RST_MU = (RST_MONTH >= 4'd10) ? (RST_MONTH - 4'd10) : RST_MONTH;

  logic [3:0] nyu, nyt, nyh, nyth;
  logic       year_wrap;
  logic [3:0] nmt, nmu;
  logic       is_dec;
  logic       load_ok;
  logic [3:0] load_mt, load_mu;

  // BCD ripple increment of the year; year_wrap flags 9999 -> 0000.
  always_comb begin
    nyu       = yu;
    nyt       = yt;
    nyh       = yh;
    nyth      = yth;
    year_wrap = 1'b0;
    if (yu != 4'd9) begin
      nyu = yu + 4'd1;
    end else begin
      nyu = 4'd0;
      if (yt != 4'd9) begin
        nyt = yt + 4'd1;
      end else begin
        nyt = 4'd0;
        if (yh != 4'd9) begin
          nyh = yh + 4'd1;
        end else begin
          nyh = 4'd0;
          if (yth != 4'd9) begin
            nyth = yth + 4'd1;
          end else begin
            nyth      = 4'd0;
            year_wrap = 1'b1;
          end
        end
      end
    end
  end

  // Month increment for the non-December case; December is handled in the register.
  always_comb begin
    is_dec = ({mt, mu} == M_DEC);
    nmt    = mt;
    nmu    = mu;
    if (mu == 4'd9) begin
      nmt = 4'd1;
      nmu = 4'd0;
    end else begin
      nmu = mu + 4'd1;
    end
  end

  always_comb begin
    load_ok = (load_month >= 4'd1) && (load_month <= 4'd12) &&
              bcd_digit_ok(load_year[15:12]) && bcd_digit_ok(load_year[11:8]) &&
              bcd_digit_ok(load_year[7:4])   && bcd_digit_ok(load_year[3:0]);
    load_mt = (load_month >= 4'd10) ? 4'd1 : 4'd0;
    load_mu = (load_month >= 4'd10) ? (load_month - 4'd10) : load_month;
  end

  // Pulses default low every cycle; load beats ce, reset beats both.
  always_ff @(posedge clk) begin
    if (rst) begin
      mt                   <= RST_MT;
      mu                   <= RST_MU;
      {yth, yh, yt, yu}    <= RST_YEAR;
      cout                 <= 1'b0;
      load_err             <= 1'b0;
    end else begin
      cout     <= 1'b0;
      load_err <= 1'b0;
      if (load_en) begin
        if (load_ok) begin
          mt                <= load_mt;
          mu                <= load_mu;
          {yth, yh, yt, yu} <= load_year;
        end else begin
          load_err <= 1'b1;
        end
      end else if (ce) begin
        if (is_dec) begin
          mt                <= 4'd0;
          mu                <= 4'd1;
          {yth, yh, yt, yu} <= {nyth, nyh, nyt, nyu};
          cout              <= year_wrap;
        end else begin
          mt <= nmt;
          mu <= nmu;
        end
      end
    end
  end

  leap_year_detect u_leap (
    .yth  (yth),
    .yh   (yh),
    .yt   (yt),
    .yu   (yu),
    .leap (leap)
  );

  always_comb begin
    case ({mt, mu})
      M_FEB:                      max_days = leap ? DAYS_29 : DAYS_28;
      M_APR, M_JUN, M_SEP, M_NOV: max_days = DAYS_30;
      default:                    max_days = DAYS_31;
    endcase
  end

endmodule
